mod_exp_ctrl: RTL

//   Left-to-right square-and-multiply sequencer computing y = base^exp mod m.

---
 rtl/mod_arith_pkg.sv | 20 ++
 rtl/mod_exp_ctrl_if.sv | 28 ++
 rtl/mod_exp_bit_sel.sv | 87 ++++++++
 rtl/mod_exp_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mod_arith_pkg.sv
// Shared definitions for the modular-exponentiation controller.
//   NBITS_DEF / EBITS_DEF : default operand and exponent widths
//   state_t               : sequencer FSM states
package mod_arith_pkg;

  localparam int NBITS_DEF = 256;
  localparam int EBITS_DEF = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SQR,
    S_SQ_WAIT,
    S_MUL,
    S_MU_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

endpackage

// File: rtl/mod_exp_ctrl_if.sv
// Link between the exponentiation sequencer and the modular multiplier.
//   master (sequencer) : drives mul_enable_p, mul_a, mul_b, mul_m;
//                        receives mul_y, mul_done_p
//   slave (multiplier) : the mirror image
interface mod_exp_ctrl_if
  import mod_arith_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
);

  logic             mul_enable_p;
  logic [NBITS-1:0] mul_a;
  logic [NBITS-1:0] mul_b;
  logic [NBITS-1:0] mul_m;
  logic [NBITS-1:0] mul_y;
  logic             mul_done_p;

  modport master (
    output mul_enable_p, mul_a, mul_b, mul_m,
    input  mul_y, mul_done_p
  );

  modport slave (
    input  mul_enable_p, mul_a, mul_b, mul_m,
    output mul_y, mul_done_p
  );

endinterface

// File: rtl/mod_exp_bit_sel.sv
// Exponent bit walker for the square-and-multiply sequencer.
// Holds the exponent in a left-shifting register so the bit under
// consideration is always the MSB, and counts the remaining bit index.
// Macro MOD_EXP_CT_EN: when defined, the leading-zero skip is disabled so
// every exponent bit is walked.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load      : capture exp_in, index := EBITS-1
//   exp_in    : exponent to capture
//   skip      : drop leading zero bits in one cycle
//   adv       : move on to the next lower bit
//   bit_o     : current exponent bit
//   last_o    : current bit is bit 0
//   zero_o    : captured exponent is zero
module mod_exp_bit_sel #(
  parameter int EBITS = 256,
  parameter int IW    = (EBITS > 1) ? $clog2(EBITS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [EBITS-1:0] exp_in,
  input  logic             skip,
  input  logic             adv,
  output logic             bit_o,
  output logic             last_o,
  output logic             zero_o
);

  logic [EBITS-1:0] exp_q, exp_d;
  logic [IW-1:0]    idx_q, idx_d;

`ifndef MOD_EXP_CT_EN
  // Number of leading zeros; only meaningful for a nonzero exponent.
  logic [IW-1:0] lz;
  logic          found;

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int k = EBITS-1; k >= 0; k--) begin
      if (!found) begin
        if (exp_q[k]) found = 1'b1;
        else          lz    = lz + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    exp_d = exp_q;
    idx_d = idx_q;
    if (load) begin
      exp_d = exp_in;
      idx_d = IW'(EBITS-1);
    end
`ifdef MOD_EXP_CT_EN
    else if (skip) begin
      idx_d = IW'(EBITS-1);
    end
`else
    else if (skip) begin
      exp_d = exp_q << lz;
      idx_d = IW'(EBITS-1) - lz;
    end
`endif
    else if (adv) begin
      exp_d = exp_q << 1;
      idx_d = idx_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q <= '0;
      idx_q <= '0;
    end else begin
      exp_q <= exp_d;
      idx_q <= idx_d;
    end
  end

  assign bit_o  = exp_q[EBITS-1];
  assign last_o = (idx_q == '0);
  assign zero_o = (exp_q == '0);

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer: result = base^exp mod m.
// Drives an external interleaved modular multiplier through the mul port,
// one enable pulse per product, and waits for its done pulse.
// Macro MOD_EXP_CT_EN: constant-time mode. All EBITS bits are walked and a
// multiply is issued for every bit; for 0-bits the product goes to a shadow
// register instead of the accumulator.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start_p     : start pulse, ignored while busy
//   base/exp/m  : operands, sampled on start_p
//   busy        : operation in progress (low again in the done cycle)
//   result, err : outcome, valid from done_irq_p until the next start
//   done_irq_p  : one-cycle completion pulse
//   mul         : multiplier link (enable, operands, modulus, product, done)
module mod_exp_ctrl
  import mod_arith_pkg::*;
#(
  parameter int NBITS = NBITS_DEF,
  parameter int EBITS = EBITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_p,
  input  logic [NBITS-1:0] base,
  input  logic [EBITS-1:0] exp,
  input  logic [NBITS-1:0] m,
  output logic             busy,
  output logic [NBITS-1:0] result,
  output logic             err,
  output logic             done_irq_p,
  mod_exp_ctrl_if.master   mul
);

  state_t           state_q, state_d;
  logic [NBITS-1:0] base_q, base_d;
  logic [NBITS-1:0] m_q, m_d;
  logic [NBITS-1:0] r_q, r_d;
  logic [NBITS-1:0] result_q, result_d;
  logic             err_q, err_d;
`ifdef MOD_EXP_CT_EN
  logic [NBITS-1:0] shadow_q, shadow_d;
`endif

  logic             ld, skip, adv;
  logic             bit_cur, bit_last, exp_zero;
  logic             en;
  logic [NBITS-1:0] op_a, op_b;

  mod_exp_bit_sel #(.EBITS(EBITS)) u_bit_sel (
    .clk    (clk),
    .rst    (rst),
    .load   (ld),
    .exp_in (exp),
    .skip   (skip),
    .adv    (adv),
    .bit_o  (bit_cur),
    .last_o (bit_last),
    .zero_o (exp_zero)
  );

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    m_d      = m_q;
    r_d      = r_q;
    result_d = result_q;
    err_d    = err_q;
`ifdef MOD_EXP_CT_EN
    shadow_d = shadow_q;
`endif
    ld   = 1'b0;
    skip = 1'b0;
    adv  = 1'b0;
    en   = 1'b0;
    op_a = '0;
    op_b = '0;
    case (state_q)
      S_IDLE: begin
        if (start_p) begin
          base_d   = base;
          m_d      = m;
          r_d      = NBITS'(1);
          result_d = '0;
          err_d    = 1'b0;
          ld       = 1'b1;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (m_q == '0 || base_q >= m_q) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = S_DONE;
        end else if (m_q == NBITS'(1)) begin
          result_d = '0;
          state_d  = S_DONE;
        end else if (exp_zero) begin
          result_d = NBITS'(1);
          state_d  = S_DONE;
        end else begin
          skip    = 1'b1;
          state_d = S_SQR;
        end
      end
      S_SQR: begin
        en      = 1'b1;
        op_a    = r_q;
        op_b    = r_q;
        state_d = S_SQ_WAIT;
      end
      S_SQ_WAIT: begin
        op_a = r_q;
        op_b = r_q;
        if (mul.mul_done_p) begin
          r_d = mul.mul_y;
`ifdef MOD_EXP_CT_EN
          state_d = S_MUL;
`else
          state_d = bit_cur ? S_MUL : S_NEXT;
`endif
        end
      end
      S_MUL: begin
        en      = 1'b1;
        op_a    = base_q;
        op_b    = r_q;
        state_d = S_MU_WAIT;
      end
      S_MU_WAIT: begin
        op_a = base_q;
        op_b = r_q;
        if (mul.mul_done_p) begin
`ifdef MOD_EXP_CT_EN
          if (bit_cur) r_d      = mul.mul_y;
          else         shadow_d = mul.mul_y;
`else
          r_d = mul.mul_y;
`endif
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (bit_last) begin
          result_d = r_q;
          state_d  = S_DONE;
        end else begin
          adv     = 1'b1;
          state_d = S_SQR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      m_q      <= '0;
      r_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
`ifdef MOD_EXP_CT_EN
      shadow_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      m_q      <= m_d;
      r_q      <= r_d;
      result_q <= result_d;
      err_q    <= err_d;
`ifdef MOD_EXP_CT_EN
      shadow_q <= shadow_d;
`endif
    end
  end

  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_irq_p = (state_q == S_DONE);
  assign result     = result_q;
  assign err        = err_q;

  // Operands are decoded from state, so they stay put for the whole wait.
  assign mul.mul_enable_p = en;
  assign mul.mul_a        = op_a;
  assign mul.mul_b        = op_b;
  assign mul.mul_m        = m_q;

endmodule
